// File: rtl/axi_lite_bridge_pkg.sv
// Shared types and constants for the 1xN AXI-Lite bridge.
// Optional error log is enabled with AXI_LITE_BRIDGE_ERRLOG_EN (see axi_lite_bridge_1xn).
package axi_lite_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ISSUE,
        WR_WAIT_B,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT_R,
        RD_RESP
    } rd_state_t;

    // Select-index width; never zero so a single-slave build still has a legal vector.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite channel bundle shared by the bridge upstream and downstream ports.
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   aw_addr;
    logic                aw_valid;
    logic                aw_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_valid;
    logic                w_ready;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                b_ready;
    logic [ADDR_W-1:0]   ar_addr;
    logic                ar_valid;
    logic                ar_ready;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_valid;
    logic                r_ready;

    modport master (
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input aw_addr, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

endinterface

// File: rtl/axi_lite_addr_decoder.sv
// Base/mask address decoder: reports a hit and the index of the matching slave.
// Lowest index wins when windows overlap.
module axi_lite_addr_decoder
    import axi_lite_bridge_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SLAVE_BASE [N_SLAVES] =
        '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000},
    parameter logic [ADDR_W-1:0] SLAVE_MASK [N_SLAVES] = '{4{32'hFFFF_F000}}
) (
    input  logic [ADDR_W-1:0]            addr,
    output logic                         hit,
    output logic [sel_w(N_SLAVES)-1:0]   sel
);

    localparam int SEL_W = sel_w(N_SLAVES);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_bridge_1xn.sv
// 1-to-N AXI-Lite bridge with base/mask decode; unmapped accesses get a local DECERR.
// Define AXI_LITE_BRIDGE_ERRLOG_EN to add a sticky first-DECERR log (err_* ports).
module axi_lite_bridge_1xn
    import axi_lite_bridge_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter logic [ADDR_W-1:0] SLAVE_BASE [N_SLAVES] =
        '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000},
    parameter logic [ADDR_W-1:0] SLAVE_MASK [N_SLAVES] = '{4{32'hFFFF_F000}}
) (
    input  logic         aclk,
    input  logic         aresetn,
    axi_lite_if.slave    up,
    axi_lite_if.master   dn [N_SLAVES]
`ifdef AXI_LITE_BRIDGE_ERRLOG_EN
    ,
    output logic              err_valid,
    output logic              err_is_write,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clear
`endif
);

    localparam int SEL_W  = sel_w(N_SLAVES);
    localparam int STRB_W = DATA_W / 8;

    logic [N_SLAVES-1:0] dn_aw_ready;
    logic [N_SLAVES-1:0] dn_w_ready;
    logic [N_SLAVES-1:0] dn_b_valid;
    logic [N_SLAVES-1:0] dn_ar_ready;
    logic [N_SLAVES-1:0] dn_r_valid;
    logic [1:0]          dn_b_resp [N_SLAVES];
    logic [1:0]          dn_r_resp [N_SLAVES];
    logic [DATA_W-1:0]   dn_r_data [N_SLAVES];

    wr_state_t           wr_state;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [SEL_W-1:0]    wr_sel;
    logic                dn_aw_valid_q;
    logic                dn_w_valid_q;
    logic                up_b_valid_q;
    logic [1:0]          b_resp_q;

    rd_state_t           rd_state;
    logic [ADDR_W-1:0]   ar_addr_q;
    logic [SEL_W-1:0]    rd_sel;
    logic                dn_ar_valid_q;
    logic                up_r_valid_q;
    logic [1:0]          r_resp_q;
    logic [DATA_W-1:0]   r_data_q;

    logic                up_aw_ready;
    logic                up_w_ready;
    logic                up_ar_ready;
    logic                aw_fire;
    logic                w_fire;
    logic                ar_fire;
    logic                wr_both_held;
    logic [ADDR_W-1:0]   aw_dec_addr;
    logic                aw_hit;
    logic [SEL_W-1:0]    aw_sel;
    logic                ar_hit;
    logic [SEL_W-1:0]    ar_sel;

    assign up_aw_ready  = aresetn && (wr_state == WR_IDLE) && !aw_held;
    assign up_w_ready   = aresetn && (wr_state == WR_IDLE) && !w_held;
    assign up_ar_ready  = aresetn && (rd_state == RD_IDLE);
    assign aw_fire      = up.aw_valid && up_aw_ready;
    assign w_fire       = up.w_valid && up_w_ready;
    assign ar_fire      = up.ar_valid && up_ar_ready;
    assign wr_both_held = (wr_state == WR_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

    // Decode the address that is being captured this cycle or was captured earlier.
    assign aw_dec_addr  = aw_held ? aw_addr_q : up.aw_addr;

    assign up.aw_ready = up_aw_ready;
    assign up.w_ready  = up_w_ready;
    assign up.ar_ready = up_ar_ready;
    assign up.b_valid  = aresetn && up_b_valid_q;
    assign up.b_resp   = b_resp_q;
    assign up.r_valid  = aresetn && up_r_valid_q;
    assign up.r_resp   = r_resp_q;
    assign up.r_data   = r_data_q;

    axi_lite_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_aw_decoder (
        .addr (aw_dec_addr),
        .hit  (aw_hit),
        .sel  (aw_sel)
    );

    axi_lite_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_ar_decoder (
        .addr (up.ar_addr),
        .hit  (ar_hit),
        .sel  (ar_sel)
    );

    // Payload is broadcast; only the selected port sees valid/ready.
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_dn
        assign dn[i].aw_addr  = aw_addr_q;
        assign dn[i].w_data   = w_data_q;
        assign dn[i].w_strb   = w_strb_q;
        assign dn[i].ar_addr  = ar_addr_q;
        assign dn[i].aw_valid = aresetn && dn_aw_valid_q && (wr_sel == SEL_W'(i));
        assign dn[i].w_valid  = aresetn && dn_w_valid_q && (wr_sel == SEL_W'(i));
        assign dn[i].b_ready  = aresetn && (wr_state == WR_WAIT_B) && (wr_sel == SEL_W'(i));
        assign dn[i].ar_valid = aresetn && dn_ar_valid_q && (rd_sel == SEL_W'(i));
        assign dn[i].r_ready  = aresetn && (rd_state == RD_WAIT_R) && (rd_sel == SEL_W'(i));

        assign dn_aw_ready[i] = dn[i].aw_ready;
        assign dn_w_ready[i]  = dn[i].w_ready;
        assign dn_b_valid[i]  = dn[i].b_valid;
        assign dn_b_resp[i]   = dn[i].b_resp;
        assign dn_ar_ready[i] = dn[i].ar_ready;
        assign dn_r_valid[i]  = dn[i].r_valid;
        assign dn_r_resp[i]   = dn[i].r_resp;
        assign dn_r_data[i]   = dn[i].r_data;
    end

    // Write path: AW and W are collected independently, then issued as one transaction.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state      <= WR_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            wr_sel        <= '0;
            dn_aw_valid_q <= 1'b0;
            dn_w_valid_q  <= 1'b0;
            up_b_valid_q  <= 1'b0;
            b_resp_q      <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_fire) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= up.aw_addr;
                    end
                    if (w_fire) begin
                        w_held   <= 1'b1;
                        w_data_q <= up.w_data;
                        w_strb_q <= up.w_strb;
                    end
                    if (wr_both_held) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        if (aw_hit) begin
                            wr_sel        <= aw_sel;
                            dn_aw_valid_q <= 1'b1;
                            dn_w_valid_q  <= 1'b1;
                            wr_state      <= WR_ISSUE;
                        end else begin
                            b_resp_q     <= RESP_DECERR;
                            up_b_valid_q <= 1'b1;
                            wr_state     <= WR_RESP;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (dn_aw_ready[wr_sel]) begin
                        dn_aw_valid_q <= 1'b0;
                    end
                    if (dn_w_ready[wr_sel]) begin
                        dn_w_valid_q <= 1'b0;
                    end
                    if ((!dn_aw_valid_q || dn_aw_ready[wr_sel]) &&
                        (!dn_w_valid_q || dn_w_ready[wr_sel])) begin
                        wr_state <= WR_WAIT_B;
                    end
                end
                WR_WAIT_B: begin
                    if (dn_b_valid[wr_sel]) begin
                        b_resp_q     <= dn_b_resp[wr_sel];
                        up_b_valid_q <= 1'b1;
                        wr_state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (up.b_ready) begin
                        up_b_valid_q <= 1'b0;
                        wr_state     <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read path: one outstanding read, fully independent of the write path.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state      <= RD_IDLE;
            ar_addr_q     <= '0;
            rd_sel        <= '0;
            dn_ar_valid_q <= 1'b0;
            up_r_valid_q  <= 1'b0;
            r_resp_q      <= '0;
            r_data_q      <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_fire) begin
                        ar_addr_q <= up.ar_addr;
                        if (ar_hit) begin
                            rd_sel        <= ar_sel;
                            dn_ar_valid_q <= 1'b1;
                            rd_state      <= RD_ISSUE;
                        end else begin
                            r_resp_q     <= RESP_DECERR;
                            r_data_q     <= '0;
                            up_r_valid_q <= 1'b1;
                            rd_state     <= RD_RESP;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (dn_ar_ready[rd_sel]) begin
                        dn_ar_valid_q <= 1'b0;
                        rd_state      <= RD_WAIT_R;
                    end
                end
                RD_WAIT_R: begin
                    if (dn_r_valid[rd_sel]) begin
                        r_resp_q     <= dn_r_resp[rd_sel];
                        r_data_q     <= dn_r_data[rd_sel];
                        up_r_valid_q <= 1'b1;
                        rd_state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (up.r_ready) begin
                        up_r_valid_q <= 1'b0;
                        rd_state     <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

`ifdef AXI_LITE_BRIDGE_ERRLOG_EN
    logic wr_decerr;
    logic rd_decerr;
    logic err_can_capture;

    assign wr_decerr       = wr_both_held && !aw_hit;
    assign rd_decerr       = ar_fire && !ar_hit;
    assign err_can_capture = !err_valid || err_clear;

    // Sticky log of the first DECERR; a clear in the same cycle as a new error keeps the new one.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_valid    <= 1'b0;
            err_is_write <= 1'b0;
            err_addr     <= '0;
        end else if (err_can_capture && wr_decerr) begin
            err_valid    <= 1'b1;
            err_is_write <= 1'b1;
            err_addr     <= aw_dec_addr;
        end else if (err_can_capture && rd_decerr) begin
            err_valid    <= 1'b1;
            err_is_write <= 1'b0;
            err_addr     <= up.ar_addr;
        end else if (err_clear) begin
            err_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_bridge_1xn.sv
// Directed testbench for axi_lite_bridge_1xn: vector table plus multi-cycle corner sequences.
// Also checks the error log when AXI_LITE_BRIDGE_ERRLOG_EN is defined.
module tb_axi_lite_bridge_1xn;
    import axi_lite_bridge_pkg::*;

    localparam int NS = 4;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) up_if ();
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) dn_if [NS] ();

`ifdef AXI_LITE_BRIDGE_ERRLOG_EN
    logic        err_valid;
    logic        err_is_write;
    logic [31:0] err_addr;
    logic        err_clear;
`endif

    axi_lite_bridge_1xn #(
        .N_SLAVES (NS),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .up      (up_if),
        .dn      (dn_if)
`ifdef AXI_LITE_BRIDGE_ERRLOG_EN
        ,
        .err_valid    (err_valid),
        .err_is_write (err_is_write),
        .err_addr     (err_addr),
        .err_clear    (err_clear)
`endif
    );

    // Slave model controls and observed downstream signals
    logic [NS-1:0] s_aw_rdy;
    logic [1:0]    s_bresp [NS];
    logic [NS-1:0] s_r_hold;
    logic [NS-1:0] dn_awv, dn_wv, dn_bready, dn_arv, dn_rready;
    logic [31:0]   dn_awaddr [NS];
    logic [31:0]   dn_wdata [NS];
    logic [3:0]    dn_wstrb [NS];
    logic [31:0]   dn_araddr [NS];

    logic [NS-1:0] sl_aw_got, sl_w_got, sl_bvalid, sl_ar_pend, sl_rvalid;
    logic [31:0]   sl_rdata [NS];
    logic [31:0]   sl_last_addr [NS];
    logic [31:0]   sl_last_data [NS];
    logic [3:0]    sl_last_strb [NS];

    for (genvar g = 0; g < NS; g++) begin : g_slv
        assign dn_if[g].aw_ready = s_aw_rdy[g];
        assign dn_if[g].w_ready  = 1'b1;
        assign dn_if[g].b_valid  = sl_bvalid[g];
        assign dn_if[g].b_resp   = s_bresp[g];
        assign dn_if[g].ar_ready = 1'b1;
        assign dn_if[g].r_valid  = sl_rvalid[g];
        assign dn_if[g].r_data   = sl_rdata[g];
        assign dn_if[g].r_resp   = RESP_OKAY;
        assign dn_awv[g]    = dn_if[g].aw_valid;
        assign dn_wv[g]     = dn_if[g].w_valid;
        assign dn_bready[g] = dn_if[g].b_ready;
        assign dn_arv[g]    = dn_if[g].ar_valid;
        assign dn_rready[g] = dn_if[g].r_ready;
        assign dn_awaddr[g] = dn_if[g].aw_addr;
        assign dn_wdata[g]  = dn_if[g].w_data;
        assign dn_wstrb[g]  = dn_if[g].w_strb;
        assign dn_araddr[g] = dn_if[g].ar_addr;
    end

    // Slaves: respond one cycle after both AW and W (or AR) have been accepted.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sl_aw_got  <= '0;
            sl_w_got   <= '0;
            sl_bvalid  <= '0;
            sl_ar_pend <= '0;
            sl_rvalid  <= '0;
            for (int i = 0; i < NS; i++) begin
                sl_rdata[i]     <= '0;
                sl_last_addr[i] <= '0;
                sl_last_data[i] <= '0;
                sl_last_strb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (dn_awv[i] && s_aw_rdy[i]) sl_last_addr[i] <= dn_awaddr[i];
                if (dn_wv[i]) begin
                    sl_last_data[i] <= dn_wdata[i];
                    sl_last_strb[i] <= dn_wstrb[i];
                end
                if (sl_bvalid[i]) begin
                    if (dn_bready[i]) sl_bvalid[i] <= 1'b0;
                end else if ((sl_aw_got[i] || (dn_awv[i] && s_aw_rdy[i])) &&
                             (sl_w_got[i] || dn_wv[i])) begin
                    sl_bvalid[i] <= 1'b1;
                    sl_aw_got[i] <= 1'b0;
                    sl_w_got[i]  <= 1'b0;
                end else begin
                    if (dn_awv[i] && s_aw_rdy[i]) sl_aw_got[i] <= 1'b1;
                    if (dn_wv[i]) sl_w_got[i] <= 1'b1;
                end
                if (dn_arv[i]) sl_rdata[i] <= {16'hC0DE, dn_araddr[i][15:0]};
                if (sl_rvalid[i]) begin
                    if (dn_rready[i]) sl_rvalid[i] <= 1'b0;
                end else if ((sl_ar_pend[i] || dn_arv[i]) && !s_r_hold[i]) begin
                    sl_rvalid[i]  <= 1'b1;
                    sl_ar_pend[i] <= 1'b0;
                end else if (dn_arv[i]) begin
                    sl_ar_pend[i] <= 1'b1;
                end
            end
        end
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_port;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs one write and/or read transaction; cycle 0 is the cycle the valids are first presented.
    task automatic applyStimulus(input logic do_wr, input logic do_rd,
                                 input logic [31:0] waddr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic [31:0] raddr,
                                 output int wlat, output logic [1:0] bresp,
                                 output int rlat, output logic [1:0] rresp,
                                 output logic [31:0] rdata, output logic [3:0] ports,
                                 output int first_dn);
        logic aw_hs, w_hs, ar_hs, b_hs, r_hs, b_done, r_done;
        wlat = -1; rlat = -1; bresp = '0; rresp = '0; rdata = '0; ports = '0; first_dn = -1;
        @(negedge aclk);
        up_if.aw_valid = do_wr;
        up_if.aw_addr  = waddr;
        up_if.w_valid  = do_wr;
        up_if.w_data   = wdata;
        up_if.w_strb   = wstrb;
        up_if.ar_valid = do_rd;
        up_if.ar_addr  = raddr;
        b_done = !do_wr;
        r_done = !do_rd;
        for (int c = 0; c < 40 && !(b_done && r_done); c++) begin
            #1;
            if ((dn_awv | dn_wv | dn_arv) != '0) begin
                ports = ports | dn_awv | dn_wv | dn_arv;
                if (first_dn < 0) first_dn = c;
            end
            aw_hs = up_if.aw_valid && up_if.aw_ready;
            w_hs  = up_if.w_valid && up_if.w_ready;
            ar_hs = up_if.ar_valid && up_if.ar_ready;
            b_hs  = 1'b0;
            r_hs  = 1'b0;
            if (!b_done && up_if.b_valid) begin
                wlat = c;
                bresp = up_if.b_resp;
                up_if.b_ready = 1'b1;
                b_hs = 1'b1;
            end
            if (!r_done && up_if.r_valid) begin
                rlat = c;
                rresp = up_if.r_resp;
                rdata = up_if.r_data;
                up_if.r_ready = 1'b1;
                r_hs = 1'b1;
            end
            @(posedge aclk);
            #1;
            if (aw_hs) up_if.aw_valid = 1'b0;
            if (w_hs)  up_if.w_valid  = 1'b0;
            if (ar_hs) up_if.ar_valid = 1'b0;
            if (b_hs) begin up_if.b_ready = 1'b0; b_done = 1'b1; end
            if (r_hs) begin up_if.r_ready = 1'b0; r_done = 1'b1; end
            @(negedge aclk);
        end
        up_if.aw_valid = 1'b0;
        up_if.w_valid  = 1'b0;
        up_if.ar_valid = 1'b0;
    endtask

    // Waits (bounded) for an upstream write response and accepts it; n = -1 on timeout.
    task automatic waitB(output logic [1:0] resp, output int n);
        n = -1;
        resp = '0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (up_if.b_valid) begin
                resp = up_if.b_resp;
                n = c;
                up_if.b_ready = 1'b1;
                @(posedge aclk);
                #1;
                up_if.b_ready = 1'b0;
                @(negedge aclk);
                break;
            end
            @(negedge aclk);
        end
    endtask

    vec_t        vecs [7];
    int          wlat, rlat, first_dn, nb;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  ports;
    logic [3:0]  exp_ports;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'h0,         3,  1};
        vecs[1] = '{1'b0, 32'h0000_5000, 32'h0,         4'h0, RESP_DECERR, 32'h0,         1, -1};
        vecs[2] = '{1'b0, 32'h0000_2010, 32'h0,         4'h0, RESP_OKAY,   32'hC0DE_2010, 3,  2};
        vecs[3] = '{1'b1, 32'h0000_3FFC, 32'h1234_5678, 4'h3, RESP_OKAY,   32'h0,         3,  3};
        vecs[4] = '{1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'hF, RESP_DECERR, 32'h0,         1, -1};
        vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, RESP_OKAY,   32'hC0DE_0FFC, 3,  0};
        vecs[6] = '{1'b0, 32'hFFFF_F000, 32'h0,         4'h0, RESP_DECERR, 32'h0,         1, -1};

        up_if.aw_valid = 1'b0; up_if.aw_addr = '0;
        up_if.w_valid  = 1'b0; up_if.w_data  = '0; up_if.w_strb = '0;
        up_if.b_ready  = 1'b0;
        up_if.ar_valid = 1'b0; up_if.ar_addr = '0;
        up_if.r_ready  = 1'b0;
        s_aw_rdy = '1;
        s_r_hold = '0;
        for (int i = 0; i < NS; i++) s_bresp[i] = RESP_OKAY;
`ifdef AXI_LITE_BRIDGE_ERRLOG_EN
        err_clear = 1'b0;
`endif
        aresetn = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        #1;
        checkOutput("rst_aw_ready", up_if.aw_ready, 0);
        checkOutput("rst_w_ready",  up_if.w_ready,  0);
        checkOutput("rst_ar_ready", up_if.ar_ready, 0);
        checkOutput("rst_up_valid", {up_if.b_valid, up_if.r_valid}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        checkOutput("idle_aw_ready", up_if.aw_ready, 1);
        checkOutput("idle_ar_ready", up_if.ar_ready, 1);
        checkOutput("idle_dn_valid", dn_awv | dn_wv | dn_arv, 0);

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].is_wr, !vecs[v].is_wr, vecs[v].addr, vecs[v].data,
                          vecs[v].strb, vecs[v].addr, wlat, bresp, rlat, rresp, rdata,
                          ports, first_dn);
            exp_ports = (vecs[v].exp_port >= 0) ? 4'(1 << vecs[v].exp_port) : 4'h0;
            if (vecs[v].is_wr) begin
                checkOutput($sformatf("v%0d_b_latency", v), wlat, vecs[v].exp_lat);
                checkOutput($sformatf("v%0d_b_resp", v), bresp, vecs[v].exp_resp);
            end else begin
                checkOutput($sformatf("v%0d_r_latency", v), rlat, vecs[v].exp_lat);
                checkOutput($sformatf("v%0d_r_resp", v), rresp, vecs[v].exp_resp);
                checkOutput($sformatf("v%0d_r_data", v), rdata, vecs[v].exp_rdata);
            end
            checkOutput($sformatf("v%0d_dn_ports", v), ports, exp_ports);
            if (vecs[v].exp_port >= 0) begin
                checkOutput($sformatf("v%0d_dn_first_cycle", v), first_dn, 1);
                if (vecs[v].is_wr) begin
                    checkOutput($sformatf("v%0d_slv_addr", v), sl_last_addr[vecs[v].exp_port], vecs[v].addr);
                    checkOutput($sformatf("v%0d_slv_data", v), sl_last_data[vecs[v].exp_port], vecs[v].data);
                    checkOutput($sformatf("v%0d_slv_strb", v), sl_last_strb[vecs[v].exp_port], vecs[v].strb);
                end
            end
        end

`ifdef AXI_LITE_BRIDGE_ERRLOG_EN
        // First DECERR (read 0x5000) stays logged despite later ones
        checkOutput("errlog_valid", err_valid, 1);
        checkOutput("errlog_addr", err_addr, 32'h0000_5000);
        checkOutput("errlog_is_write", err_is_write, 0);
        @(negedge aclk);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        #1;
        checkOutput("errlog_cleared", err_valid, 0);
        applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h0, wlat, bresp, rlat, rresp,
                      rdata, ports, first_dn);
        checkOutput("errlog2_valid", err_valid, 1);
        checkOutput("errlog2_addr", err_addr, 32'h0000_4000);
        checkOutput("errlog2_is_write", err_is_write, 1);
`endif

        // W three cycles ahead of AW
        @(negedge aclk);
        up_if.w_valid = 1'b1;
        up_if.w_data  = 32'hA5A5_5A5A;
        up_if.w_strb  = 4'hF;
        #1;
        checkOutput("early_w_ready", up_if.w_ready, 1);
        @(posedge aclk);
        #1;
        up_if.w_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge aclk);
            #1;
            checkOutput($sformatf("early_w_held_c%0d", c), up_if.w_ready, 0);
            checkOutput($sformatf("early_w_no_dn_c%0d", c), dn_awv | dn_wv, 0);
        end
        @(negedge aclk);
        up_if.aw_valid = 1'b1;
        up_if.aw_addr  = 32'h0000_2000;
        #1;
        checkOutput("early_w_no_dn_aw_cycle", dn_awv | dn_wv, 0);
        @(posedge aclk);
        #1;
        up_if.aw_valid = 1'b0;
        @(negedge aclk);
        #1;
        checkOutput("early_w_dn_aw_valid", dn_awv, 4'b0100);
        checkOutput("early_w_dn_w_valid", dn_wv, 4'b0100);
        @(negedge aclk);
        waitB(bresp, nb);
        checkOutput("early_w_b_seen", nb >= 0, 1);
        checkOutput("early_w_b_resp", bresp, RESP_OKAY);
        checkOutput("early_w_slv_addr", sl_last_addr[2], 32'h0000_2000);
        checkOutput("early_w_slv_data", sl_last_data[2], 32'hA5A5_5A5A);

        // dn[3] stalls aw_ready for five cycles, then answers SLVERR
        s_aw_rdy[3] = 1'b0;
        s_bresp[3]  = RESP_SLVERR;
        @(negedge aclk);
        up_if.aw_valid = 1'b1;
        up_if.aw_addr  = 32'h0000_3000;
        up_if.w_valid  = 1'b1;
        up_if.w_data   = 32'h0BAD_F00D;
        up_if.w_strb   = 4'hF;
        @(posedge aclk);
        #1;
        up_if.aw_valid = 1'b0;
        up_if.w_valid  = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge aclk);
            #1;
            checkOutput($sformatf("stall_aw_valid_c%0d", c), dn_awv, 4'b1000);
            checkOutput($sformatf("stall_aw_addr_c%0d", c), dn_awaddr[3], 32'h0000_3000);
        end
        @(negedge aclk);
        s_aw_rdy[3] = 1'b1;
        waitB(bresp, nb);
        checkOutput("stall_b_seen", nb >= 0, 1);
        checkOutput("stall_b_resp", bresp, RESP_SLVERR);
        s_bresp[3] = RESP_OKAY;

        // Concurrent write and read to the same slave
        applyStimulus(1'b1, 1'b1, 32'h0000_0000, 32'h1111_2222, 4'hF, 32'h0000_0010,
                      wlat, bresp, rlat, rresp, rdata, ports, first_dn);
        checkOutput("conc_b_latency", wlat, 3);
        checkOutput("conc_r_latency", rlat, 3);
        checkOutput("conc_b_resp", bresp, RESP_OKAY);
        checkOutput("conc_r_data", rdata, 32'hC0DE_0010);
        checkOutput("conc_slv_data", sl_last_data[0], 32'h1111_2222);

        // Reset pulse while the read waits for R
        s_r_hold[1] = 1'b1;
        @(negedge aclk);
        up_if.ar_valid = 1'b1;
        up_if.ar_addr  = 32'h0000_1008;
        @(posedge aclk);
        #1;
        up_if.ar_valid = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        checkOutput("rst_mid_wait_r_ready", dn_rready, 4'b0010);
        aresetn = 1'b0;
        #1;
        checkOutput("rst_mid_forced_ready", {up_if.ar_ready, up_if.aw_ready, dn_rready}, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        s_r_hold[1] = 1'b0;
        @(negedge aclk);
        #1;
        checkOutput("rst_mid_idle_ar_ready", up_if.ar_ready, 1);
        checkOutput("rst_mid_no_valid", {up_if.r_valid, up_if.b_valid, dn_awv, dn_wv, dn_arv, dn_rready}, 0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_1008,
                      wlat, bresp, rlat, rresp, rdata, ports, first_dn);
        checkOutput("rst_mid_next_r_latency", rlat, 3);
        checkOutput("rst_mid_next_r_data", rdata, 32'hC0DE_1008);
        checkOutput("rst_mid_next_ports", ports, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
